// File: rtl/serial_pkg.sv
`timescale 1ns/1ps
// Shared types and constants for the serial receiver/transmitter pair.
// Defining SERIAL_RX_PARITY_EN adds the PARITY state to the receiver FSM.
package serial_pkg;

  localparam int DEF_CLK_FREQ_HZ = 50_000_000;
  localparam int DEF_BAUD        = 115200;
  localparam int DEF_OVERSAMPLE  = 16;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_STOP      = 3'd3,
`ifdef SERIAL_RX_PARITY_EN
    ST_PARITY    = 3'd5,
`endif
    ST_WAIT_HIGH = 3'd4
  } rx_state_e;

  // Clocks per oversample tick, rounded to nearest.
  function automatic int calc_divider(input int clk_hz, input int baud, input int os);
    int den;
    den = baud * os;
    return (clk_hz + den / 2) / den;
  endfunction

endpackage

// File: rtl/baud_tick_gen.sv
`timescale 1ns/1ps
// Oversample tick generator: one-cycle tick every DIV clocks; clear holds the
// count at zero so the first tick lands DIV clocks after clear drops.
module baud_tick_gen
  import serial_pkg::*;
#(
  parameter int DIV = calc_divider(DEF_CLK_FREQ_HZ, DEF_BAUD, DEF_OVERSAMPLE)
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    tick  = (cnt_q == CW'(DIV - 1)) && !clear;
    cnt_d = cnt_q + 1'b1;
    if (clear || tick) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/serial_receiver.sv
`timescale 1ns/1ps
// Oversampling 8N1 UART receiver with framing-error and overrun reporting.
// Defining SERIAL_RX_PARITY_EN adds an even-parity bit and a parity_err pulse.
module serial_receiver
  import serial_pkg::*;
#(
  parameter int CLK_FREQ_HZ = DEF_CLK_FREQ_HZ,
  parameter int BAUD        = DEF_BAUD,
  parameter int OVERSAMPLE  = DEF_OVERSAMPLE
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  input  logic       rd,
  output logic [7:0] out_data,
  output logic       data_valid,
  output logic       frame_err,
  output logic       overrun,
`ifdef SERIAL_RX_PARITY_EN
  output logic       parity_err,
`endif
  output logic       busy
);

  localparam int DIV_RAW = calc_divider(CLK_FREQ_HZ, BAUD, OVERSAMPLE);
  localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int TW      = (OVERSAMPLE > 2) ? $clog2(OVERSAMPLE) : 1;
  localparam logic [TW-1:0] HALF_LAST = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] FULL_LAST = TW'(OVERSAMPLE - 1);

  rx_state_e     state_q, state_d;
  logic          rx_meta_q, rx_meta_d, rx_sync_q, rx_sync_d, rx_prev_q, rx_prev_d;
  logic [TW-1:0] tick_cnt_q, tick_cnt_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d, out_data_q, out_data_d;
  logic          data_valid_q, data_valid_d, frame_err_q, frame_err_d;
  logic          overrun_q, overrun_d;
  logic          tick, sample;
`ifdef SERIAL_RX_PARITY_EN
  logic          parity_bad_q, parity_bad_d, parity_err_q, parity_err_d;
`endif

  baud_tick_gen #(.DIV(DIV)) u_tick (
    .clk   (clk),
    .reset (reset),
    .clear (state_q == ST_IDLE),
    .tick  (tick)
  );

  always_comb begin
    rx_meta_d    = rx;
    rx_sync_d    = rx_meta_q;
    rx_prev_d    = rx_sync_q;
    state_d      = state_q;
    tick_cnt_d   = tick_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    out_data_d   = out_data_q;
    data_valid_d = data_valid_q;
    overrun_d    = overrun_q;
    frame_err_d  = 1'b0;
`ifdef SERIAL_RX_PARITY_EN
    parity_bad_d = parity_bad_q;
    parity_err_d = 1'b0;
`endif
    // START samples mid-bit; later states sample one full bit apart.
    sample = tick && (tick_cnt_q == ((state_q == ST_START) ? HALF_LAST : FULL_LAST));
    if (tick) tick_cnt_d = sample ? '0 : tick_cnt_q + 1'b1;

    if (rd && data_valid_q) begin
      data_valid_d = 1'b0;
      overrun_d    = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        tick_cnt_d = '0;
        bit_cnt_d  = '0;
        if (rx_prev_q && !rx_sync_q) state_d = ST_START;
      end
      ST_START: begin
        if (sample) state_d = rx_sync_q ? ST_IDLE : ST_DATA;
      end
      ST_DATA: begin
        if (sample) begin
          shift_d   = {rx_sync_q, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 1'b1;
`ifdef SERIAL_RX_PARITY_EN
          if (bit_cnt_q == 3'd7) state_d = ST_PARITY;
`else
          if (bit_cnt_q == 3'd7) state_d = ST_STOP;
`endif
        end
      end
`ifdef SERIAL_RX_PARITY_EN
      ST_PARITY: begin
        if (sample) begin
          parity_bad_d = (^shift_q) ^ rx_sync_q;
          state_d      = ST_STOP;
        end
      end
`endif
      ST_STOP: begin
        if (sample) begin
`ifdef SERIAL_RX_PARITY_EN
          parity_err_d = parity_bad_q;
`endif
          if (rx_sync_q) begin
            // A load beats a coincident rd: valid stays set, overrun holds.
            out_data_d   = shift_q;
            data_valid_d = 1'b1;
            overrun_d    = overrun_q | (data_valid_q & ~rd);
            state_d      = ST_IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = ST_WAIT_HIGH;
          end
        end
      end
      ST_WAIT_HIGH: begin
        if (rx_sync_q) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_meta_q    <= 1'b1;
      rx_sync_q    <= 1'b1;
      rx_prev_q    <= 1'b1;
      state_q      <= ST_IDLE;
      tick_cnt_q   <= '0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      out_data_q   <= '0;
      data_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
`ifdef SERIAL_RX_PARITY_EN
      parity_bad_q <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      rx_meta_q    <= rx_meta_d;
      rx_sync_q    <= rx_sync_d;
      rx_prev_q    <= rx_prev_d;
      state_q      <= state_d;
      tick_cnt_q   <= tick_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      out_data_q   <= out_data_d;
      data_valid_q <= data_valid_d;
      frame_err_q  <= frame_err_d;
      overrun_q    <= overrun_d;
`ifdef SERIAL_RX_PARITY_EN
      parity_bad_q <= parity_bad_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  assign out_data   = out_data_q;
  assign data_valid = data_valid_q;
  assign frame_err  = frame_err_q;
  assign overrun    = overrun_q;
  assign busy       = (state_q != ST_IDLE);
`ifdef SERIAL_RX_PARITY_EN
  assign parity_err = parity_err_q;
`endif

endmodule
